seg7_scan_decoder: RTL and testbench

- Monitors a multiplexed, active-low 7-segment display bus: per-digit anode strobes plus a shared 8-bit segment bus in our a..g,dp bit order.
- Reconstructs the hex nibble, decimal point and blank/error status of every digit.
- Receive-side counterpart of our hex-to-segment decoder and anode scanner.
- Used for self-checking display loopback and for capturing external display boards into the register file.

---
 rtl/seg7_scan_decoder.sv | 79 +++++++
 tb/tb_seg7_scan_decoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers per-digit hex nibble, dp, blank and error status
// from a multiplexed active-low 7-segment anode/segment bus.
module seg7_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int SETTLE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     an,
  input  logic [7:0]            sgm,
  output logic [4*DIGITS-1:0]   digits_o,
  output logic [DIGITS-1:0]     dp_o,
  output logic [DIGITS-1:0]     blank_o,
  output logic [DIGITS-1:0]     err_o,
  output logic                  upd_o,
  output logic                  frame_o,
  output logic                  coll_o
);
  localparam int W = DIGITS + 8;
  localparam logic [6:0] HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic [W-1:0]      r1, r2;
  logic [7:0]        cnt;
  logic [DIGITS-1:0] seen, sel, seen_nx;
  logic              fire, none, one_hot, cap, hit, blank;
  logic [3:0]        nib;
  always_comb begin
    fire    = (r1 == r2) && (cnt == 8'(SETTLE - 1));
    sel     = ~r1[W-1:8];
    none    = sel == '0;
    one_hot = !none && ((sel & (sel - DIGITS'(1))) == '0);
    cap     = fire && one_hot;
    blank   = r1[7:1] == '1;
    seen_nx = seen | sel;
    hit     = 1'b0;
    nib     = 4'd0;
    for (int v = 0; v < 16; v++)
      if (r1[7:1] == HEX[v]) begin
        hit = 1'b1;
        nib = 4'(v);
      end
  end
  // cnt saturates at SETTLE so a held pattern matches SETTLE-1 only once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r1       <= '1;
      r2       <= '1;
      cnt      <= '0;
      seen     <= '0;
      digits_o <= '0;
      dp_o     <= '0;
      err_o    <= '0;
      blank_o  <= '1;
      upd_o    <= 1'b0;
      frame_o  <= 1'b0;
      coll_o   <= 1'b0;
    end else begin
      r1      <= {an, sgm};
      r2      <= r1;
      cnt     <= (r1 != r2) ? '0 : (cnt == 8'(SETTLE)) ? cnt : cnt + 8'd1;
      upd_o   <= cap;
      coll_o  <= fire && !one_hot && !none;
      frame_o <= cap && (seen_nx == '1);
      if (cap) begin
        seen <= (seen_nx == '1) ? '0 : seen_nx;
        for (int i = 0; i < DIGITS; i++)
          if (sel[i]) begin
            dp_o[i]    <= ~r1[0];
            blank_o[i] <= blank;
            err_o[i]   <= !hit && !blank;
            if (hit) digits_o[4*i +: 4] <= nib;
          end
      end
    end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: random and directed scan traffic against a
// run-length reference model, with a queue-based pulse scoreboard.
module tb_seg7_scan_decoder;
  localparam int DIGITS = 4;
  localparam int SETTLE = 4;
  localparam logic [6:0] HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an = '1;
  logic [7:0]  sgm = '1;
  logic [15:0] digits_o;
  logic [3:0]  dp_o, blank_o, err_o;
  logic        upd_o, frame_o, coll_o;
  typedef struct {
    int          stamp;
    logic        upd, coll, frame;
    logic [15:0] dig;
    logic [3:0]  dp, bl, er;
  } exp_t;
  exp_t        q[$];
  int          checks = 0, failures = 0, edges = 0;
  logic [11:0] prev;
  int          run;
  logic [3:0]  seen, m_dp, m_bl, m_er;
  logic [15:0] m_dig;

  seg7_scan_decoder #(.DIGITS(DIGITS), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .sgm(sgm), .digits_o(digits_o),
    .dp_o(dp_o), .blank_o(blank_o), .err_o(err_o), .upd_o(upd_o),
    .frame_o(frame_o), .coll_o(coll_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic model_reset();
    prev  = '1;
    run   = 2;
    seen  = '0;
    m_dig = '0;
    m_dp  = '0;
    m_bl  = '1;
    m_er  = '0;
    q.delete();
  endtask

  // A pattern sampled SETTLE+1 times in a row is decided at that edge and shows one edge later.
  task automatic model();
    logic [11:0] cur;
    int          lows, idx, v;
    logic        bl, fr;
    cur  = {an, sgm};
    run  = (cur == prev) ? (run < 1000 ? run + 1 : run) : 1;
    prev = cur;
    if (run != SETTLE + 1) return;
    lows = 0;
    idx  = 0;
    for (int i = 0; i < DIGITS; i++)
      if (!an[i]) begin
        lows++;
        idx = i;
      end
    if (lows >= 2) q.push_back('{edges + 2, 1'b0, 1'b1, 1'b0, m_dig, m_dp, m_bl, m_er});
    else if (lows == 1) begin
      v = -1;
      for (int k = 0; k < 16; k++) if (HEX[k] == sgm[7:1]) v = k;
      bl = sgm[7:1] == 7'h7f;
      m_dp[idx] = ~sgm[0];
      m_bl[idx] = bl;
      m_er[idx] = (v < 0) && !bl;
      if (v >= 0) m_dig[4*idx +: 4] = 4'(v);
      seen[idx] = 1'b1;
      fr = seen == 4'hF;
      if (fr) seen = '0;
      q.push_back('{edges + 2, 1'b1, 1'b0, fr, m_dig, m_dp, m_bl, m_er});
    end
  endtask

  task automatic step(input logic [3:0] a, input logic [7:0] s, input int n);
    repeat (n) begin
      @(negedge clk);
      an  = a;
      sgm = s;
      model();
    end
  endtask

  task automatic check_reset(input string name);
    checks++;
    if ({digits_o, dp_o, err_o, blank_o, upd_o, frame_o, coll_o} != {16'h0, 4'h0, 4'h0, 4'hF, 3'b000}) begin
      failures++;
      $display("FAIL %s got digits=%h dp=%b err=%b blank=%b pulses=%b%b%b want 0000/0000/0000/1111/000",
               name, digits_o, dp_o, err_o, blank_o, upd_o, frame_o, coll_o);
    end
  endtask

  task automatic reset_pulse(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1 check_reset("reset_async");
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    model();
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      while (q.size() > 0 && q[0].stamp < edges) begin
        checks++;
        failures++;
        $display("FAIL missing_pulse expected at edge %0d, still absent at edge %0d", q[0].stamp, edges);
        void'(q.pop_front());
      end
      if (upd_o || coll_o || frame_o) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL spurious_pulse edge %0d upd/coll/frame=%b%b%b want none", edges, upd_o, coll_o, frame_o);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.stamp != edges || {upd_o, coll_o, frame_o} != {e.upd, e.coll, e.frame} ||
              digits_o != e.dig || dp_o != e.dp || blank_o != e.bl || err_o != e.er) begin
            failures++;
            $display("FAIL pulse edge=%0d want %0d upd/coll/frame=%b%b%b want %b%b%b digits=%h want %h dp=%b want %b blank=%b want %b err=%b want %b",
                     edges, e.stamp, upd_o, coll_o, frame_o, e.upd, e.coll, e.frame,
                     digits_o, e.dig, dp_o, e.dp, blank_o, e.bl, err_o, e.er);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] a;
    logic [7:0] s;
    int         r;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("reset_hold");
    rst_n = 1'b1;
    model();
    step(4'b1110, 8'b00100101, 25);
    step(4'b0111, 8'b00000011, 3);
    reset_pulse(3);
    step(4'b0111, 8'b00000011, 10);
    step(4'b1101, 8'b10000100, 4);
    step(4'b1111, 8'hFF, 6);
    step(4'b1101, 8'b10000100, 5);
    step(4'b1111, 8'hFF, 6);
    step(4'b1011, 8'hFF, 6);
    step(4'b1011, 8'b01010101, 6);
    step(4'b1111, 8'hFF, 6);
    step(4'b1100, 8'b00100101, 6);
    step(4'b1111, 8'hFF, 6);
    reset_pulse(2);
    repeat (2) begin
      foreach (HEX[k]) if (k < 5) begin
        r = (k == 0 || k == 2) ? 0 : (k == 1) ? 1 : k - 1;
        a = 4'hF;
        a[r] = 1'b0;
        step(a, {HEX[k + 3], 1'b1}, 6);
        step(4'hF, 8'hFF, 3);
      end
    end
    for (int n = 0; n < 160; n++) begin
      r = $urandom_range(0, 9);
      a = (r < 2) ? 4'hF : (r < 3) ? 4'($urandom) : ~(4'b1 << $urandom_range(0, 3));
      r = $urandom_range(0, 9);
      s = (r < 1) ? 8'hFF : (r < 2) ? 8'($urandom) : {HEX[$urandom_range(0, 15)], 1'($urandom)};
      if ($urandom_range(0, 39) == 0) reset_pulse($urandom_range(1, 3));
      step(a, s, $urandom_range(1, 8));
    end
    step(4'hF, 8'hFF, 12);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
